ip_output_packer: RTL and testbench
===================================

IP_OUTPUT_PACKER -- requirements
Module: ip_output_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of 16-bit word entries (power of two, >=2).
REQ-002 SHALL have parameter PAD_BYTE, default 8'h00, filler used for the low byte of a flushed half word.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_data  input  8  byte from the upstream IP's data_output.
REQ-006 SHALL have port in_valid  input  1  in_data qualifier (upstream valid_output); no backpressure to upstream.
REQ-007 SHALL have port flush  input  1  single-cycle request to emit any held half word.
REQ-008 SHALL have port out_data  output  16  packed word, first-received byte in [15:8].
REQ-009 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port out_ready  input  1  consumer accept; a pop occurs when out_valid && out_ready.
REQ-011 SHALL have port out_partial  output  1  head word holds only one real byte.
REQ-012 SHALL have port overflow  output  1  sticky: a word was dropped.
REQ-013 SHALL have port drop_count  output  8  dropped-word count, saturating at 255.
REQ-014 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH+1)  current occupancy.

Function
REQ-015 SHALL implement assembler FSM states EMPTY and HALF; in_valid in EMPTY latches in_data into a holding byte and goes to HALF.
REQ-016 SHALL, on in_valid in HALF, push {hold, in_data} with partial=0 and return to EMPTY in the same cycle.
REQ-017 SHALL, on flush without in_valid in HALF, push {hold, PAD_BYTE} with partial=1 and return to EMPTY.
REQ-018 SHALL, on flush with in_valid in HALF, push the completed word normally; flush has no further effect.
REQ-019 SHALL, on flush with in_valid in EMPTY, push {in_data, PAD_BYTE} with partial=1 and stay in EMPTY.
REQ-020 SHALL, on flush in EMPTY without in_valid, take no action.
REQ-021 SHALL make a pushed word visible on out_data/out_valid the cycle after the push (1-cycle latency), first-word fall-through thereafter.
REQ-022 SHALL accept a push when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-023 SHALL, on a push that cannot be accepted, discard the word, set overflow, and increment drop_count (saturating); the FSM still advances to EMPTY.
REQ-024 SHALL keep out_data/out_partial stable while out_valid && !out_ready.
REQ-025 SHALL wrap read/write pointers modulo FIFO_DEPTH; fifo_level SHALL equal pushes minus pops.

Reset
REQ-026 SHALL, while rst is high at a clock edge, set the FSM to EMPTY, the holding byte to 0, the FIFO to empty, out_valid=0, out_data=0, out_partial=0, overflow=0, drop_count=0, fifo_level=0.
REQ-027 SHALL, when rst is asserted mid-operation, discard any held byte and all FIFO contents with no flush emission; rst takes priority over all inputs.

Configuration
REQ-028 SHALL, when PACKER_PARITY_EN is defined, add output out_parity[1:0] (bit1 = XOR of out_data[15:8], bit0 = XOR of out_data[7:0]), stored per entry, reset 0.
REQ-029 SHALL, without PACKER_PARITY_EN, have no out_parity port and no parity storage.

Structure
REQ-030 SHALL place the FSM state enum (EMPTY/HALF) and the word/entry struct (data, partial, optional parity) in shared package ip_output_packer_pkg.
REQ-031 SHALL implement the FIFO as sub-module packer_sync_fifo; the assembler FSM and drop counter stay in ip_output_packer.

Verification
REQ-032 SHALL cover: rst, then bytes 0xA1, 0xB2 with out_ready=1 -> out_data=16'hA1B2, out_partial=0, out_valid one cycle after 0xB2.
REQ-033 SHALL cover: byte 0x5C, then flush alone -> out_data=16'h5C00, out_partial=1.
REQ-034 SHALL cover: out_ready=0, 10 back-to-back bytes, FIFO_DEPTH=4 -> fifo_level=4, overflow=1, drop_count=1, first word intact.
REQ-035 SHALL cover: FIFO full, out_ready=1 in the push cycle -> word accepted, fifo_level stays 4, drop_count unchanged.
REQ-036 SHALL cover: 300 dropped words -> drop_count=255; then rst mid-HALF -> all outputs 0 and no partial word emitted.
REQ-037 SHALL cover, with PACKER_PARITY_EN: word 16'h0301 -> out_parity=2'b01.

Source files
------------

// File: rtl/ip_output_packer_pkg.sv
// Shared types for the byte-to-halfword output packer.
// Optional PACKER_PARITY_EN adds per-entry byte parity to the FIFO entry.
package ip_output_packer_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } asm_state_t;

    typedef struct packed {
        logic [15:0] data;
        logic        partial;
`ifdef PACKER_PARITY_EN
        logic [1:0]  parity;
`endif
    } pack_entry_t;

    function automatic pack_entry_t make_entry(input logic [15:0] data, input logic partial);
        pack_entry_t e;
        e         = '0;
        e.data    = data;
        e.partial = partial;
`ifdef PACKER_PARITY_EN
        e.parity  = {^data[15:8], ^data[7:0]};
`endif
        return e;
    endfunction

endpackage

// File: rtl/packer_sync_fifo.sv
// Registered-storage FIFO for packed words; head is read combinationally from
// storage, so a pushed word appears the cycle after its push.
module packer_sync_fifo
    import ip_output_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  pack_entry_t                          push_entry,
    input  logic                                 pop_ready,
    output pack_entry_t                          head,
    output logic                                 head_valid,
    output logic                                 accept,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("packer_sync_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    pack_entry_t        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               full;
    logic               pop;

    assign full       = (level == LVL_W'(FIFO_DEPTH));
    assign head_valid = (level != '0);
    assign head       = mem[rd_ptr];
    assign pop        = head_valid && pop_ready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign accept     = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ip_output_packer.sv
// Packs an unthrottled byte stream into 16-bit words (first byte high) with a
// flush for odd bytes; drops words when full. PACKER_PARITY_EN adds out_parity.
module ip_output_packer
    import ip_output_packer_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] PAD_BYTE   = 8'h00
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        in_data,
    input  logic                              in_valid,
    input  logic                              flush,
    output logic [15:0]                       out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_partial,
    output logic                              overflow,
    output logic [7:0]                        drop_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
`ifdef PACKER_PARITY_EN
    ,
    output logic [1:0]                        out_parity
`endif
);

    asm_state_t  state, next_state;
    logic [7:0]  hold;
    logic        hold_load;
    logic        push;
    logic [15:0] push_data;
    logic        push_partial;
    logic        accept;
    pack_entry_t push_entry;
    pack_entry_t head;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_EMPTY: if (in_valid && !flush) next_state = ST_HALF;
            ST_HALF:  if (in_valid || flush)  next_state = ST_EMPTY;
            default:  next_state = ST_EMPTY;
        endcase
    end

    // A completed pair always wins over flush; flush alone only pads.
    always_comb begin
        push         = 1'b0;
        push_data    = '0;
        push_partial = 1'b0;
        hold_load    = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_valid && flush) begin
                    push         = 1'b1;
                    push_data    = {in_data, PAD_BYTE};
                    push_partial = 1'b1;
                end else if (in_valid) begin
                    hold_load = 1'b1;
                end
            end
            ST_HALF: begin
                if (in_valid) begin
                    push      = 1'b1;
                    push_data = {hold, in_data};
                end else if (flush) begin
                    push         = 1'b1;
                    push_data    = {hold, PAD_BYTE};
                    push_partial = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)            hold <= '0;
        else if (hold_load) hold <= in_data;
    end

    assign push_entry = make_entry(push_data, push_partial);

    packer_sync_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop_ready  (out_ready),
        .head       (head),
        .head_valid (out_valid),
        .accept     (accept),
        .level      (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (push && !accept) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
        end
    end

    assign out_data    = head.data;
    assign out_partial = head.partial;
`ifdef PACKER_PARITY_EN
    assign out_parity  = head.parity;
`endif

endmodule

// File: tb/tb_ip_output_packer.sv
// Self-checking bench: directed table, hand corner sequences, random vs queue model.
module tb_ip_output_packer;

    localparam int         DEPTH = 4;
    localparam logic [7:0] PAD   = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_partial;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [2:0]  fifo_level;
`ifdef PACKER_PARITY_EN
    logic [1:0]  out_parity;
`endif

    always #5 clk = ~clk;

    ip_output_packer #(.FIFO_DEPTH(DEPTH), .PAD_BYTE(PAD)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_partial(out_partial), .overflow(overflow), .drop_count(drop_count),
        .fifo_level(fifo_level)
`ifdef PACKER_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a bounded word queue plus an optional pending byte.
    logic [16:0] mq[$];
    bit          m_held = 0;
    logic [7:0]  m_hb = '0;
    bit          m_ovf = 0;
    int          m_drops = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("level", 32'(fifo_level), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_count", 32'(drop_count), 32'((m_drops > 255) ? 255 : m_drops));
        if (mq.size() != 0) begin
            chk("data", 32'(out_data), 32'(mq[0][16:1]));
            chk("partial", 32'(out_partial), 32'(mq[0][0]));
`ifdef PACKER_PARITY_EN
            chk("parity", 32'(out_parity), 32'({^mq[0][16:9], ^mq[0][8:1]}));
`endif
        end
    endtask

    task automatic step(input logic iv, input logic [7:0] d, input logic fl,
                        input logic rdy, input logic r = 1'b0);
        bit          pop, have, acc;
        logic [16:0] w;
        rst = r; in_valid = iv; in_data = d; flush = fl; out_ready = rdy;
        pop = (mq.size() != 0) && rdy;
        have = 0; w = '0;
        @(posedge clk);
        if (r) begin
            mq.delete(); m_held = 0; m_hb = '0; m_ovf = 0; m_drops = 0;
        end else begin
            if (iv && m_held)       begin have = 1; w = {m_hb, d, 1'b0}; m_held = 0; end
            else if (iv && fl)      begin have = 1; w = {d, PAD, 1'b1}; end
            else if (iv)            begin m_held = 1; m_hb = d; end
            else if (fl && m_held)  begin have = 1; w = {m_hb, PAD, 1'b1}; m_held = 0; end
            acc = (mq.size() < DEPTH) || pop;
            if (pop) void'(mq.pop_front());
            if (have) begin
                if (acc) mq.push_back(w);
                else begin m_ovf = 1; m_drops++; end
            end
        end
        @(negedge clk);
        cmp_model();
    endtask

    typedef struct {
        logic iv; logic [7:0] d; logic fl; logic rdy;
        logic ev; logic [15:0] ed; logic ep; int el;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 0};
        tbl[1] = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 16'hA1B2, 1'b0, 1};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 0};
        tbl[3] = '{1'b1, 8'h5C, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'h5C00, 1'b1, 1};
        tbl[5] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 16'h5C00, 1'b1, 2};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'h5C00, 1'b1, 2};
        tbl[7] = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 16'h7700, 1'b1, 1};
        tbl[8] = '{1'b1, 8'h34, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 1};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 0};

        @(negedge clk);
        step(0, 8'h00, 0, 0, 1);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_partial", 32'(out_partial), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_drop", 32'(drop_count), 0);

        foreach (tbl[i]) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].el));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
                chk($sformatf("tbl%0d_partial", i), 32'(out_partial), 32'(tbl[i].ep));
            end
        end

        // Overflow: 10 bytes into a 4-deep FIFO with no consumer.
        step(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 8'(8'h10 + i), 0, 0);
        chk("ovf_level", 32'(fifo_level), 4);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_drops", 32'(drop_count), 1);
        chk("ovf_head", 32'(out_data), 32'h1011);

        // Full FIFO with pop in the push cycle: word accepted.
        step(1, 8'h20, 0, 0);
        step(1, 8'h21, 0, 1);
        chk("fullpop_level", 32'(fifo_level), 4);
        chk("fullpop_drops", 32'(drop_count), 1);
        chk("fullpop_head", 32'(out_data), 32'h1213);

        // Saturate the drop counter, then reset while a byte is held.
        for (int i = 0; i < 600; i++) step(1, 8'(i), 0, 0);
        chk("sat_drops", 32'(drop_count), 255);
        step(1, 8'hEE, 0, 0);
        step(0, 8'h00, 0, 1, 1);
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_data", 32'(out_data), 0);
        chk("midrst_partial", 32'(out_partial), 0);
        chk("midrst_ovf", 32'(overflow), 0);
        chk("midrst_drops", 32'(drop_count), 0);
        chk("midrst_level", 32'(fifo_level), 0);
        step(0, 8'h00, 1, 1);
        step(0, 8'h00, 0, 1);
        chk("midrst_noemit", 32'(out_valid), 0);

`ifdef PACKER_PARITY_EN
        step(1, 8'h03, 0, 0);
        step(1, 8'h01, 0, 0);
        chk("parity_0301", 32'(out_parity), 32'h1);
        step(0, 8'h00, 0, 0, 1);
        chk("parity_rst", 32'(out_parity), 0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 299) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
